// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths, write-request bundle and grant encoding for the
// register-file write arbiter and its scoreboard.
package regwrite_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t dst;
        reg_data_t data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // Register x0 is hardwired, so it never maps to a scoreboard bit.
    function automatic logic [REG_COUNT-1:0] reg_onehot(
        input reg_addr_t r,
        input logic      en
    );
        reg_onehot = '0;
        if (en && (r != '0)) begin
            reg_onehot[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regwrite_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on
// issue, cleared when the write port presents the write; set wins.
module regwrite_scoreboard
    import regwrite_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_reg,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_reg,
    input  logic [REG_ADDR_W-1:0] rd_reg1,
    input  logic [REG_ADDR_W-1:0] rd_reg2,
    output logic                  busy1,
    output logic                  busy2
);

    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_next;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;

    always_comb begin
        set_mask        = reg_onehot(set_reg, set_valid);
        clr_mask        = reg_onehot(clr_reg, clr_valid);
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign busy1 = pending[rd_reg1];
    assign busy2 = pending[rd_reg2];

endmodule

// File: rtl/regwrite_arbiter.sv
// Two-source register-file write arbiter with starvation guard, one-cycle
// write port and pending-write scoreboard. Optional REGWRITE_BYPASS_EN.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_req,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ack,
    input  logic                  mem_req,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [REG_DATA_W-1:0] mem_data,
    output logic                  mem_ack,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [REG_DATA_W-1:0] wr_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    input  logic [REG_ADDR_W-1:0] rd_reg1,
    input  logic [REG_ADDR_W-1:0] rd_reg2,
    output logic                  busy1,
    output logic                  busy2
`ifdef REGWRITE_BYPASS_EN
    ,
    output logic                  byp1_valid,
    output logic [REG_DATA_W-1:0] byp1_data,
    output logic                  byp2_valid,
    output logic [REG_DATA_W-1:0] byp2_data
`endif
);

    localparam int STARVE_CLOG = $clog2(STARVE_LIMIT + 1);
    localparam int STARVE_W    = (STARVE_CLOG < 2) ? 2 : STARVE_CLOG;

    wr_req_t               alu_in;
    wr_req_t               mem_in;
    wr_req_t               win;
    grant_t                grant;
    logic [STARVE_W-1:0]   starve;
    logic                  starved;
    logic                  sb_busy1;
    logic                  sb_busy2;

    assign alu_in  = '{valid: alu_req, dst: alu_reg, data: alu_data};
    assign mem_in  = '{valid: mem_req, dst: mem_reg, data: mem_data};
    assign starved = (starve == STARVE_W'(STARVE_LIMIT));

    // Loads normally win; a starved ALU takes one grant to clear its count.
    always_comb begin
        grant = GNT_NONE;
        win   = '0;
        if (reset_n) begin
            if (alu_in.valid && (!mem_in.valid || starved)) begin
                grant = GNT_ALU;
            end else if (mem_in.valid) begin
                grant = GNT_MEM;
            end
        end
        unique case (grant)
            GNT_ALU: win = alu_in;
            GNT_MEM: win = mem_in;
            default: win = '0;
        endcase
    end

    assign alu_ack = (grant == GNT_ALU);
    assign mem_ack = (grant == GNT_MEM);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (alu_ack) begin
            starve <= '0;
        end else if (alu_req && !starved) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // Writes to x0 are acknowledged but never reach the register file.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= win.valid && (win.dst != '0);
            if (win.valid) begin
                wr_reg  <= win.dst;
                wr_data <= win.data;
            end
        end
    end

    regwrite_scoreboard u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .set_valid (issue_valid),
        .set_reg   (issue_reg),
        .clr_valid (wr_en),
        .clr_reg   (wr_reg),
        .rd_reg1   (rd_reg1),
        .rd_reg2   (rd_reg2),
        .busy1     (sb_busy1),
        .busy2     (sb_busy2)
    );

`ifdef REGWRITE_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = wr_en && (wr_reg != '0) && (wr_reg == rd_reg1);
    assign hit2 = wr_en && (wr_reg != '0) && (wr_reg == rd_reg2);

    assign byp1_valid = hit1;
    assign byp2_valid = hit2;
    assign byp1_data  = hit1 ? wr_data : '0;
    assign byp2_data  = hit2 ? wr_data : '0;

    // A forwarded value satisfies the read unless a new issue reclaims it.
    assign busy1 = hit1 ? (issue_valid && (issue_reg == rd_reg1)) : sb_busy1;
    assign busy2 = hit2 ? (issue_valid && (issue_reg == rd_reg2)) : sb_busy2;
`else
    assign busy1 = sb_busy1;
    assign busy2 = sb_busy2;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_regwrite_arbiter;

    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_req;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ack;
    logic        mem_req;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic        busy1;
    logic        busy2;
`ifdef REGWRITE_BYPASS_EN
    logic        byp1_valid;
    logic [31:0] byp1_data;
    logic        byp2_valid;
    logic [31:0] byp2_data;
`endif

    regwrite_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_req     (alu_req),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .alu_ack     (alu_ack),
        .mem_req     (mem_req),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .busy1       (busy1),
        .busy2       (busy2)
`ifdef REGWRITE_BYPASS_EN
        ,
        .byp1_valid  (byp1_valid),
        .byp1_data   (byp1_data),
        .byp2_valid  (byp2_valid),
        .byp2_data   (byp2_data)
`endif
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_starve = 0;
    bit          m_pend[32];
    bit          m_wr_en = 0;
    logic [4:0]  m_wr_reg = '0;
    logic [31:0] m_wr_data = '0;
    bit          last_aa = 0;
    bit          last_ma = 0;

    typedef struct {
        logic        a_req;
        logic [4:0]  a_reg;
        logic [31:0] a_data;
        logic        m_req;
        logic [4:0]  m_reg;
        logic [31:0] m_data;
        logic        e_aack;
        logic        e_mack;
        logic        e_wen;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge against the model, advance at posedge.
    task automatic cycle();
        bit aa;
        bit ma;
        bit b1;
        bit b2;
`ifdef REGWRITE_BYPASS_EN
        bit h1;
        bit h2;
`endif
        @(negedge clock);
        aa = 0;
        ma = 0;
        if (reset_n) begin
            if (alu_req && (!mem_req || m_starve >= LIMIT)) aa = 1;
            else if (mem_req) ma = 1;
        end
        check("alu_ack", alu_ack, aa);
        check("mem_ack", mem_ack, ma);
        check("wr_en", wr_en, m_wr_en);
        if (m_wr_en) begin
            check("wr_reg", wr_reg, m_wr_reg);
            check("wr_data", wr_data, m_wr_data);
        end
        b1 = (rd_reg1 != 0) && m_pend[rd_reg1];
        b2 = (rd_reg2 != 0) && m_pend[rd_reg2];
`ifdef REGWRITE_BYPASS_EN
        h1 = m_wr_en && (rd_reg1 != 0) && (m_wr_reg == rd_reg1);
        h2 = m_wr_en && (rd_reg2 != 0) && (m_wr_reg == rd_reg2);
        if (h1) b1 = issue_valid && (issue_reg == rd_reg1);
        if (h2) b2 = issue_valid && (issue_reg == rd_reg2);
        check("byp1_valid", byp1_valid, h1);
        check("byp2_valid", byp2_valid, h2);
        if (h1) check("byp1_data", byp1_data, m_wr_data);
        if (h2) check("byp2_data", byp2_data, m_wr_data);
`endif
        check("busy1", busy1, b1);
        check("busy2", busy2, b2);
        last_aa = aa;
        last_ma = ma;
        @(posedge clock);
        if (!reset_n) begin
            m_starve = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
            m_wr_en   = 0;
            m_wr_reg  = '0;
            m_wr_data = '0;
        end else begin
            if (m_wr_en) m_pend[m_wr_reg] = 0;
            if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1;
            if (aa) m_starve = 0;
            else if (alu_req) m_starve = m_starve + 1;
            m_wr_en = (aa && alu_reg != 0) || (ma && mem_reg != 0);
            if (aa) begin
                m_wr_reg  = alu_reg;
                m_wr_data = alu_data;
            end else if (ma) begin
                m_wr_reg  = mem_reg;
                m_wr_data = mem_data;
            end
        end
        #1;
    endtask

    initial begin
        foreach (m_pend[i]) m_pend[i] = 0;
        reset_n     = 1'b0;
        alu_req     = 1'b0;
        alu_reg     = '0;
        alu_data    = '0;
        mem_req     = 1'b0;
        mem_reg     = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
        rd_reg1     = 5'd1;
        rd_reg2     = 5'd2;
        cycle();
        cycle();
        reset_n = 1'b1;
        #2;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_reg", wr_reg, 5'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy1", busy1, 1'b0);

        // a_req a_reg a_data  m_req m_reg m_data  aack mack wen wreg wdata
        tbl[0] = '{0, 0,  0,          0, 0,  0,          0, 0, 0, 0,  0};
        tbl[1] = '{1, 5,  32'h1234,   0, 0,  0,          1, 0, 1, 5,  32'h1234};
        tbl[2] = '{0, 0,  0,          1, 8,  32'hBEEF,   0, 1, 1, 8,  32'hBEEF};
        tbl[3] = '{1, 7,  32'h77,     1, 3,  32'h33,     0, 1, 1, 3,  32'h33};
        tbl[4] = '{1, 7,  32'h77,     0, 0,  0,          1, 0, 1, 7,  32'h77};
        tbl[5] = '{0, 0,  0,          1, 0,  32'hFFFF,   0, 1, 0, 0,  0};
        tbl[6] = '{1, 0,  32'h55,     0, 0,  0,          1, 0, 0, 0,  0};
        tbl[7] = '{1, 10, 32'hA,      1, 11, 32'hB,      0, 1, 1, 11, 32'hB};
        tbl[8] = '{1, 10, 32'hA,      1, 12, 32'hC,      0, 1, 1, 12, 32'hC};
        tbl[9] = '{1, 10, 32'hA,      0, 0,  0,          1, 0, 1, 10, 32'hA};
        for (int i = 0; i < 10; i++) begin
            alu_req  = tbl[i].a_req;
            alu_reg  = tbl[i].a_reg;
            alu_data = tbl[i].a_data;
            mem_req  = tbl[i].m_req;
            mem_reg  = tbl[i].m_reg;
            mem_data = tbl[i].m_data;
            #2;
            check($sformatf("tbl%0d_alu_ack", i), alu_ack, tbl[i].e_aack);
            check($sformatf("tbl%0d_mem_ack", i), mem_ack, tbl[i].e_mack);
            cycle();
            check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                check($sformatf("tbl%0d_wr_reg", i), wr_reg, tbl[i].e_wreg);
                check($sformatf("tbl%0d_wr_data", i), wr_data,
                      tbl[i].e_wdata);
            end
        end
        alu_req = 1'b0;
        mem_req = 1'b0;
        cycle();

        // Starvation: mem wins LIMIT times, then alu, then mem again.
        alu_req  = 1'b1;
        alu_reg  = 5'd7;
        alu_data = 32'h700;
        mem_req  = 1'b1;
        mem_reg  = 5'd8;
        mem_data = 32'h800;
        for (int k = 0; k <= LIMIT + 1; k++) begin
            if (k == LIMIT + 1) begin
                alu_data = 32'h701;
            end
            #2;
            check($sformatf("starve%0d_alu_ack", k), alu_ack, k == LIMIT);
            check($sformatf("starve%0d_mem_ack", k), mem_ack, k != LIMIT);
            cycle();
        end
        alu_req = 1'b0;
        mem_req = 1'b0;
        cycle();

        // Scoreboard set, clear on write, set-wins on collision.
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        rd_reg1     = 5'd9;
        cycle();
        issue_valid = 1'b0;
        #2;
        check("sb_set", busy1, 1'b1);
        cycle();
        alu_req  = 1'b1;
        alu_reg  = 5'd9;
        alu_data = 32'h99;
        #2;
        check("sb_busy_hold", busy1, 1'b1);
        cycle();
        alu_req = 1'b0;
        #2;
        check("sb_wr_present", wr_en, 1'b1);
`ifdef REGWRITE_BYPASS_EN
        check("sb_busy_at_write", busy1, 1'b0);
`else
        check("sb_busy_at_write", busy1, 1'b1);
`endif
        cycle();
        #2;
        check("sb_cleared", busy1, 1'b0);
        issue_valid = 1'b1;
        cycle();
        issue_valid = 1'b0;
        alu_req     = 1'b1;
        cycle();
        alu_req     = 1'b0;
        issue_valid = 1'b1;
        #2;
        check("sb_collide_now", busy1, 1'b1);
        cycle();
        issue_valid = 1'b0;
        #2;
        check("sb_set_wins", busy1, 1'b1);
        cycle();

        // Register x0: acked but not written, never tracked.
        mem_req  = 1'b1;
        mem_reg  = 5'd0;
        mem_data = 32'hFFFF;
        #2;
        check("x0_mem_ack", mem_ack, 1'b1);
        cycle();
        mem_req = 1'b0;
        #2;
        check("x0_wr_en", wr_en, 1'b0);
        issue_valid = 1'b1;
        issue_reg   = 5'd0;
        rd_reg1     = 5'd0;
        cycle();
        issue_valid = 1'b0;
        #2;
        check("x0_busy1", busy1, 1'b0);
        cycle();

        // Reset while both requesters are pending.
        issue_valid = 1'b1;
        issue_reg   = 5'd4;
        rd_reg1     = 5'd4;
        rd_reg2     = 5'd9;
        cycle();
        issue_valid = 1'b0;
        alu_req     = 1'b1;
        alu_reg     = 5'd13;
        alu_data    = 32'hD;
        mem_req     = 1'b1;
        mem_reg     = 5'd14;
        mem_data    = 32'hE;
        reset_n     = 1'b0;
        #2;
        check("rst_mid_alu_ack", alu_ack, 1'b0);
        check("rst_mid_mem_ack", mem_ack, 1'b0);
        cycle();
        reset_n = 1'b1;
        alu_req = 1'b0;
        mem_req = 1'b0;
        #2;
        check("rst_mid_wr_en", wr_en, 1'b0);
        check("rst_mid_busy1", busy1, 1'b0);
        check("rst_mid_busy2", busy2, 1'b0);
        cycle();

`ifdef REGWRITE_BYPASS_EN
        alu_req  = 1'b1;
        alu_reg  = 5'd12;
        alu_data = 32'hABCD;
        rd_reg2  = 5'd12;
        cycle();
        alu_req = 1'b0;
        #2;
        check("byp_valid", byp2_valid, 1'b1);
        check("byp_data", byp2_data, 32'hABCD);
        check("byp_busy2", busy2, 1'b0);
        cycle();
`endif

        // Randomized traffic obeying hold-until-ack.
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            if (!alu_req || last_aa) begin
                alu_req  = $urandom_range(0, 1);
                alu_reg  = 5'($urandom_range(0, 15));
                alu_data = $urandom;
            end
            if (!mem_req || last_ma) begin
                mem_req  = ($urandom_range(0, 3) != 0);
                mem_reg  = 5'($urandom_range(0, 15));
                mem_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1);
            issue_reg   = 5'($urandom_range(0, 15));
            rd_reg1     = 5'($urandom_range(0, 15));
            rd_reg2     = 5'($urandom_range(0, 15));
            cycle();
        end
        reset_n = 1'b1;
        alu_req = 1'b0;
        mem_req = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
